// File: rtl/ex_mem_pipe_reg_2way_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ex_mem_pipe_reg_2way_pkg : shared core widths, lane field types, taken helper
// Rev 1.0
// ----------------------------------------------------------------------------
package ex_mem_pipe_reg_2way_pkg;

  localparam int CORE_XLEN   = 64;
  localparam int CORE_NREG_W = 5;
  localparam int CNT_W       = 32;

  // Per-lane control fields; these must read as zero whenever the lane is invalid.
  typedef struct packed {
    logic reg_wr;
    logic mem_rd;
    logic mem_wr;
  } lane_ctl_t;

  typedef enum logic [0:0] {
    SEL_LANE0 = 1'b0,
    SEL_LANE1 = 1'b1
  } lane_sel_e;

  // br_n is the ALU's inverted outcome: 0 means the branch condition held.
  function automatic logic lane_taken(input logic vld, input logic is_br, input logic br_n);
    return vld & is_br & ~br_n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ex_mem_pipe_reg_2way_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ex_mem_pipe_reg_2way_if : EX->MEM two-lane bundle, handshake and redirect bus
// Rev 1.0
// ----------------------------------------------------------------------------
interface ex_mem_pipe_reg_2way_if
  import ex_mem_pipe_reg_2way_pkg::*;
#(
  parameter int XLEN   = CORE_XLEN,
  parameter int NREG_W = CORE_NREG_W
);
  logic              in_valid;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic              flush;

  logic              vld_0,     vld_1;
  logic              is_br_0,   is_br_1;
  logic [XLEN-1:0]   alu_res_0, alu_res_1;
  logic              br_n_0,    br_n_1;
  logic [XLEN-1:0]   br_tgt_0,  br_tgt_1;
  logic [NREG_W-1:0] rd_0,      rd_1;
  logic              reg_wr_0,  reg_wr_1;
  logic              mem_rd_0,  mem_rd_1;
  logic              mem_wr_0,  mem_wr_1;
  logic [XLEN-1:0]   st_data_0, st_data_1;

  logic              q_vld_0,     q_vld_1;
  logic [XLEN-1:0]   q_alu_res_0, q_alu_res_1;
  logic [NREG_W-1:0] q_rd_0,      q_rd_1;
  logic              q_reg_wr_0,  q_reg_wr_1;
  logic              q_mem_rd_0,  q_mem_rd_1;
  logic              q_mem_wr_0,  q_mem_wr_1;
  logic [XLEN-1:0]   q_st_data_0, q_st_data_1;

  logic              redirect_valid;
  logic [XLEN-1:0]   redirect_pc;
  logic [CNT_W-1:0]  br_taken_cnt;
  // Counter preload path, so wrap behaviour is reachable without 2^32 branches.
  logic              cnt_load;
  logic [CNT_W-1:0]  cnt_load_val;

  modport slave (
    input  in_valid, out_ready, flush, cnt_load, cnt_load_val,
    input  vld_0, is_br_0, alu_res_0, br_n_0, br_tgt_0, rd_0, reg_wr_0, mem_rd_0, mem_wr_0, st_data_0,
    input  vld_1, is_br_1, alu_res_1, br_n_1, br_tgt_1, rd_1, reg_wr_1, mem_rd_1, mem_wr_1, st_data_1,
    output in_ready, out_valid, redirect_valid, redirect_pc, br_taken_cnt,
    output q_vld_0, q_alu_res_0, q_rd_0, q_reg_wr_0, q_mem_rd_0, q_mem_wr_0, q_st_data_0,
    output q_vld_1, q_alu_res_1, q_rd_1, q_reg_wr_1, q_mem_rd_1, q_mem_wr_1, q_st_data_1
  );

  modport master (
    output in_valid, out_ready, flush, cnt_load, cnt_load_val,
    output vld_0, is_br_0, alu_res_0, br_n_0, br_tgt_0, rd_0, reg_wr_0, mem_rd_0, mem_wr_0, st_data_0,
    output vld_1, is_br_1, alu_res_1, br_n_1, br_tgt_1, rd_1, reg_wr_1, mem_rd_1, mem_wr_1, st_data_1,
    input  in_ready, out_valid, redirect_valid, redirect_pc, br_taken_cnt,
    input  q_vld_0, q_alu_res_0, q_rd_0, q_reg_wr_0, q_mem_rd_0, q_mem_wr_0, q_st_data_0,
    input  q_vld_1, q_alu_res_1, q_rd_1, q_reg_wr_1, q_mem_rd_1, q_mem_wr_1, q_st_data_1
  );

endinterface
`default_nettype wire

// File: rtl/ex_mem_pipe_reg_2way_lane.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ex_mem_lane_reg : single-lane field register with load / clear / squash
// Rev 1.0
// ----------------------------------------------------------------------------
module ex_mem_lane_reg
  import ex_mem_pipe_reg_2way_pkg::*;
#(
  parameter int XLEN   = CORE_XLEN,
  parameter int NREG_W = CORE_NREG_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic              squash,
  input  logic              vld,
  input  logic [XLEN-1:0]   alu_res,
  input  logic [NREG_W-1:0] rd,
  input  lane_ctl_t         ctl,
  input  logic [XLEN-1:0]   st_data,
  output logic              q_vld,
  output logic [XLEN-1:0]   q_alu_res,
  output logic [NREG_W-1:0] q_rd,
  output lane_ctl_t         q_ctl,
  output logic [XLEN-1:0]   q_st_data
);

  logic w_keep;
  assign w_keep = vld & ~squash;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_vld     <= 1'b0;
      q_ctl     <= '0;
      q_alu_res <= '0;
      q_rd      <= '0;
      q_st_data <= '0;
    end else if (clear) begin
      q_vld <= 1'b0;
      q_ctl <= '0;
    end else if (load) begin
      q_vld     <= w_keep;
      q_ctl     <= w_keep ? ctl : '0;
      q_alu_res <= alu_res;
      q_rd      <= rd;
      q_st_data <= st_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ex_mem_pipe_reg_2way.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ex_mem_pipe_reg_2way : two-lane EX/MEM register with branch redirect & count
// Rev 1.0
// ----------------------------------------------------------------------------
module ex_mem_pipe_reg_2way
  import ex_mem_pipe_reg_2way_pkg::*;
#(
  parameter int XLEN   = CORE_XLEN,
  parameter int NREG_W = CORE_NREG_W
) (
  input logic                    clk,
  input logic                    rst_n,
  ex_mem_pipe_reg_2way_if.slave  bus
);

  logic             w_in_ready;
  logic             w_capture;
  logic             w_load;
  logic             w_taken_0;
  logic             w_taken_1;
  logic             w_any_taken;
  lane_sel_e        w_sel;
  logic [XLEN-1:0]  w_tgt;
  lane_ctl_t        w_ctl_0,   w_ctl_1;
  lane_ctl_t        w_q_ctl_0, w_q_ctl_1;

  logic             r_out_valid;
  logic             r_redirect_valid;
  logic [XLEN-1:0]  r_redirect_pc;
  logic [CNT_W-1:0] r_br_taken_cnt;

  assign w_in_ready  = ~r_out_valid | bus.out_ready;
  assign w_capture   = bus.in_valid & w_in_ready;
  assign w_load      = w_capture & ~bus.flush;
  assign w_taken_0   = lane_taken(bus.vld_0, bus.is_br_0, bus.br_n_0);
  assign w_taken_1   = lane_taken(bus.vld_1, bus.is_br_1, bus.br_n_1);
  assign w_any_taken = w_taken_0 | w_taken_1;
  assign w_sel       = w_taken_0 ? SEL_LANE0 : SEL_LANE1;
  assign w_tgt       = (w_sel == SEL_LANE0) ? bus.br_tgt_0 : bus.br_tgt_1;

  assign w_ctl_0 = '{reg_wr: bus.reg_wr_0, mem_rd: bus.mem_rd_0, mem_wr: bus.mem_wr_0};
  assign w_ctl_1 = '{reg_wr: bus.reg_wr_1, mem_rd: bus.mem_rd_1, mem_wr: bus.mem_wr_1};

  ex_mem_lane_reg #(.XLEN(XLEN), .NREG_W(NREG_W)) u_lane0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (w_load),
    .clear     (bus.flush),
    .squash    (1'b0),
    .vld       (bus.vld_0),
    .alu_res   (bus.alu_res_0),
    .rd        (bus.rd_0),
    .ctl       (w_ctl_0),
    .st_data   (bus.st_data_0),
    .q_vld     (bus.q_vld_0),
    .q_alu_res (bus.q_alu_res_0),
    .q_rd      (bus.q_rd_0),
    .q_ctl     (w_q_ctl_0),
    .q_st_data (bus.q_st_data_0)
  );

  // Lane1 is younger, so a taken branch in lane0 kills it.
  ex_mem_lane_reg #(.XLEN(XLEN), .NREG_W(NREG_W)) u_lane1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (w_load),
    .clear     (bus.flush),
    .squash    (w_taken_0),
    .vld       (bus.vld_1),
    .alu_res   (bus.alu_res_1),
    .rd        (bus.rd_1),
    .ctl       (w_ctl_1),
    .st_data   (bus.st_data_1),
    .q_vld     (bus.q_vld_1),
    .q_alu_res (bus.q_alu_res_1),
    .q_rd      (bus.q_rd_1),
    .q_ctl     (w_q_ctl_1),
    .q_st_data (bus.q_st_data_1)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid      <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
    end else begin
      r_redirect_valid <= 1'b0;
      if (bus.flush) begin
        r_out_valid <= 1'b0;
      end else if (w_capture) begin
        r_out_valid <= 1'b1;
        if (w_any_taken) begin
          r_redirect_valid <= 1'b1;
          r_redirect_pc    <= w_tgt;
        end
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // One increment per bundle even if both lanes are taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_br_taken_cnt <= '0;
    end else if (bus.cnt_load) begin
      r_br_taken_cnt <= bus.cnt_load_val;
    end else if (w_load && w_any_taken) begin
      r_br_taken_cnt <= r_br_taken_cnt + 1'b1;
    end
  end

  assign bus.in_ready       = w_in_ready;
  assign bus.out_valid      = r_out_valid;
  assign bus.redirect_valid = r_redirect_valid;
  assign bus.redirect_pc    = r_redirect_pc;
  assign bus.br_taken_cnt   = r_br_taken_cnt;
  assign bus.q_reg_wr_0     = w_q_ctl_0.reg_wr;
  assign bus.q_mem_rd_0     = w_q_ctl_0.mem_rd;
  assign bus.q_mem_wr_0     = w_q_ctl_0.mem_wr;
  assign bus.q_reg_wr_1     = w_q_ctl_1.reg_wr;
  assign bus.q_mem_rd_1     = w_q_ctl_1.mem_rd;
  assign bus.q_mem_wr_1     = w_q_ctl_1.mem_wr;

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_pipe_reg_2way.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_ex_mem_pipe_reg_2way : directed self-checking bench for ex_mem_pipe_reg_2way
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_ex_mem_pipe_reg_2way;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  ex_mem_pipe_reg_2way_if #(.XLEN(64), .NREG_W(5)) bus ();

  ex_mem_pipe_reg_2way #(.XLEN(64), .NREG_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.in_valid = 0; bus.out_ready = 1; bus.flush = 0;
    bus.cnt_load = 0; bus.cnt_load_val = '0;
    bus.vld_0 = 0; bus.is_br_0 = 0; bus.alu_res_0 = '0; bus.br_n_0 = 1; bus.br_tgt_0 = '0;
    bus.rd_0 = '0; bus.reg_wr_0 = 0; bus.mem_rd_0 = 0; bus.mem_wr_0 = 0; bus.st_data_0 = '0;
    bus.vld_1 = 0; bus.is_br_1 = 0; bus.alu_res_1 = '0; bus.br_n_1 = 1; bus.br_tgt_1 = '0;
    bus.rd_1 = '0; bus.reg_wr_1 = 0; bus.mem_rd_1 = 0; bus.mem_wr_1 = 0; bus.st_data_1 = '0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 0;
    clear_inputs();
    step();
    step();
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_q_vld_0", bus.q_vld_0, 0);
    check("rst_cnt", bus.br_taken_cnt, 0);
    rst_n = 1;

    // plain capture
    bus.in_valid = 1; bus.vld_0 = 1; bus.vld_1 = 1;
    bus.alu_res_0 = 5; bus.alu_res_1 = 7; bus.rd_0 = 3; bus.reg_wr_0 = 1;
    bus.mem_wr_1 = 1; bus.st_data_1 = 64'hAB;
    step();
    clear_inputs();
    check("cap_out_valid", bus.out_valid, 1);
    check("cap_alu_0", bus.q_alu_res_0, 5);
    check("cap_alu_1", bus.q_alu_res_1, 7);
    check("cap_rd_0", bus.q_rd_0, 3);
    check("cap_reg_wr_0", bus.q_reg_wr_0, 1);
    check("cap_mem_wr_1", bus.q_mem_wr_1, 1);
    check("cap_st_data_1", bus.q_st_data_1, 64'hAB);
    check("cap_redirect", bus.redirect_valid, 0);
    step();
    check("drain_out_valid", bus.out_valid, 0);

    // lane0 taken (lane1 also taken: still one count, lane0 target)
    bus.in_valid = 1; bus.vld_0 = 1; bus.is_br_0 = 1; bus.br_n_0 = 0; bus.br_tgt_0 = 64'h100;
    bus.vld_1 = 1; bus.reg_wr_1 = 1; bus.is_br_1 = 1; bus.br_n_1 = 0; bus.br_tgt_1 = 64'h200;
    step();
    clear_inputs();
    check("t0_q_vld_0", bus.q_vld_0, 1);
    check("t0_q_vld_1", bus.q_vld_1, 0);
    check("t0_q_reg_wr_1", bus.q_reg_wr_1, 0);
    check("t0_redirect", bus.redirect_valid, 1);
    check("t0_redirect_pc", bus.redirect_pc, 64'h100);
    check("t0_cnt", bus.br_taken_cnt, 1);
    step();
    check("t0_redirect_pulse", bus.redirect_valid, 0);

    // lane1 taken, lane0 branch not taken
    bus.in_valid = 1; bus.vld_0 = 1; bus.is_br_0 = 1; bus.br_n_0 = 1; bus.br_tgt_0 = 64'h250;
    bus.vld_1 = 1; bus.is_br_1 = 1; bus.br_n_1 = 0; bus.br_tgt_1 = 64'h300;
    step();
    clear_inputs();
    check("t1_q_vld_1", bus.q_vld_1, 1);
    check("t1_redirect", bus.redirect_valid, 1);
    check("t1_redirect_pc", bus.redirect_pc, 64'h300);
    check("t1_cnt", bus.br_taken_cnt, 2);

    // bubble with a branch on an invalid lane
    bus.in_valid = 1; bus.is_br_0 = 1; bus.br_n_0 = 0; bus.br_tgt_0 = 64'h400; bus.reg_wr_0 = 1;
    step();
    clear_inputs();
    check("bub_out_valid", bus.out_valid, 1);
    check("bub_q_vld_0", bus.q_vld_0, 0);
    check("bub_q_reg_wr_0", bus.q_reg_wr_0, 0);
    check("bub_redirect", bus.redirect_valid, 0);
    check("bub_cnt", bus.br_taken_cnt, 2);
    step();

    // backpressure
    bus.in_valid = 1; bus.vld_0 = 1; bus.alu_res_0 = 64'h11; bus.out_ready = 0;
    step();
    check("bp_out_valid", bus.out_valid, 1);
    check("bp_q_alu_0", bus.q_alu_res_0, 64'h11);
    bus.alu_res_0 = 64'h22;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_hold_alu_0", bus.q_alu_res_0, 64'h11);
    end
    bus.out_ready = 1;
    #1;
    check("bp_release_in_ready", bus.in_ready, 1);
    step();
    clear_inputs();
    check("bp_new_alu_0", bus.q_alu_res_0, 64'h22);
    check("bp_new_out_valid", bus.out_valid, 1);
    step();

    // flush of a held bundle
    bus.in_valid = 1; bus.vld_0 = 1; bus.reg_wr_0 = 1; bus.out_ready = 0;
    step();
    clear_inputs();
    bus.out_ready = 0; bus.flush = 1;
    step();
    clear_inputs();
    check("fl_out_valid", bus.out_valid, 0);
    check("fl_q_vld_0", bus.q_vld_0, 0);
    check("fl_q_reg_wr_0", bus.q_reg_wr_0, 0);

    // flush with simultaneous taken capture
    bus.in_valid = 1; bus.flush = 1; bus.vld_0 = 1;
    bus.vld_1 = 1; bus.is_br_1 = 1; bus.br_n_1 = 0; bus.br_tgt_1 = 64'h500;
    step();
    clear_inputs();
    check("flc_out_valid", bus.out_valid, 0);
    check("flc_q_vld_1", bus.q_vld_1, 0);
    check("flc_redirect", bus.redirect_valid, 0);
    check("flc_cnt", bus.br_taken_cnt, 2);

    // counter wrap
    bus.cnt_load = 1; bus.cnt_load_val = 32'hFFFF_FFFF;
    step();
    clear_inputs();
    check("wrap_preload", bus.br_taken_cnt, 32'hFFFF_FFFF);
    bus.in_valid = 1; bus.vld_0 = 1; bus.is_br_0 = 1; bus.br_n_0 = 0; bus.br_tgt_0 = 64'h700;
    step();
    clear_inputs();
    check("wrap_cnt", bus.br_taken_cnt, 0);
    check("wrap_redirect_pc", bus.redirect_pc, 64'h700);
    step();

    // reset during backpressure
    bus.in_valid = 1; bus.vld_0 = 1; bus.vld_1 = 1; bus.alu_res_0 = 64'h33; bus.st_data_1 = 64'h44;
    bus.reg_wr_0 = 1; bus.mem_rd_1 = 1; bus.out_ready = 0;
    bus.is_br_0 = 1; bus.br_n_0 = 0; bus.br_tgt_0 = 64'h800;
    step();
    check("prer_out_valid", bus.out_valid, 1);
    check("prer_cnt", bus.br_taken_cnt, 1);
    rst_n = 0;
    step();
    check("rr_out_valid", bus.out_valid, 0);
    check("rr_q_vld_0", bus.q_vld_0, 0);
    check("rr_q_vld_1", bus.q_vld_1, 0);
    check("rr_q_alu_0", bus.q_alu_res_0, 0);
    check("rr_q_st_data_1", bus.q_st_data_1, 0);
    check("rr_q_reg_wr_0", bus.q_reg_wr_0, 0);
    check("rr_q_mem_rd_1", bus.q_mem_rd_1, 0);
    check("rr_redirect", bus.redirect_valid, 0);
    check("rr_redirect_pc", bus.redirect_pc, 0);
    check("rr_cnt", bus.br_taken_cnt, 0);
    check("rr_in_ready", bus.in_ready, 1);
    rst_n = 1;
    clear_inputs();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ex_mem_pipe_reg_2way.md
EX_MEM_PIPE_REG_2WAY -- requirements
Module: ex_mem_pipe_reg_2way

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning datapath width.
REQ-002 SHALL have parameter NREG_W, default 5, meaning register-index width.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-005 SHALL have port in_valid  input  1  EX bundle valid (both lanes).
REQ-006 SHALL have port in_ready  output  1  stage can accept a bundle.
REQ-007 SHALL have per lane k=0,1 inputs:
- vld_k 1
- is_br_k 1
- alu_res_k XLEN
- br_n_k 1, ALU branch outcome, 0 = condition met (taken)
- br_tgt_k XLEN
- rd_k NREG_W
- reg_wr_k 1
- mem_rd_k 1
- mem_wr_k 1
- st_data_k XLEN
REQ-008 SHALL have port out_valid  output  1  MEM bundle valid.
REQ-009 SHALL have port out_ready  input  1  MEM accepts bundle.
REQ-010 SHALL have per-lane registered outputs q_vld_k, q_alu_res_k, q_rd_k, q_reg_wr_k, q_mem_rd_k, q_mem_wr_k, q_st_data_k, same widths as inputs.
REQ-011 SHALL have port flush  input  1  younger-stage squash.
REQ-012 SHALL have port redirect_valid  output  1  one-cycle fetch redirect.
REQ-013 SHALL have port redirect_pc  output  XLEN  redirect target.
REQ-014 SHALL have port br_taken_cnt  output  32  taken-branch counter.

Function
REQ-015 SHALL hold one bundle register; in_ready = !out_valid | out_ready.
REQ-016 SHALL capture on in_valid & in_ready; out_valid then rises next cycle (latency 1).
REQ-017 SHALL hold all q_* stable while out_valid & !out_ready.
REQ-018 SHALL drop out_valid after a handshake with no new capture.
REQ-019 SHALL define lane k taken = vld_k & is_br_k & !br_n_k.
REQ-020 SHALL, when lane0 is taken, capture q_vld_1 = 0 (lane1 squashed).
REQ-021 SHALL assert redirect_valid for exactly the cycle after a taken capture; redirect_pc = br_tgt_0 if lane0 taken, else br_tgt_1.
REQ-022 SHALL increment br_taken_cnt by 1 per captured bundle containing a taken branch, never by 2; wraps at 2^32-1 -> 0.
REQ-023 SHALL force q_reg_wr_k, q_mem_rd_k and q_mem_wr_k to 0 whenever q_vld_k is 0.
REQ-024 SHALL, on flush, clear out_valid and both q_vld_k next cycle; flush wins over simultaneous capture (no redirect, no count).
REQ-025 SHALL treat a bundle with in_valid=1 and both vld_k=0 as a bubble: out_valid=1, no redirect, no count.

Reset
REQ-026 SHALL, on rst_n=0 at a clock edge, set out_valid, q_vld_k, q_reg_wr_k, q_mem_rd_k, q_mem_wr_k, redirect_valid = 0, all data q_*/redirect_pc = 0, br_taken_cnt = 0.
REQ-027 SHALL give reset priority over flush and capture; a bundle in flight at reset is discarded.
REQ-028 SHALL keep in_ready = 1 during reset (out_valid = 0).

Structure
REQ-029 SHALL take XLEN, NREG_W and the per-lane bundle field list from the shared core package.
REQ-030 SHALL instantiate one sub-module, ex_mem_lane_reg, twice (one per lane), holding a single lane's fields with load/clear/squash controls.
REQ-031 SHALL keep taken detection, redirect and counter logic at top level.

Verification
REQ-032 SHALL check capture: both lanes valid, no branch, alu_res_0=5, alu_res_1=7, out_ready=1 -> next cycle out_valid=1, q_alu_res_0=5, q_alu_res_1=7, redirect_valid=0.
REQ-033 SHALL check lane0 taken: is_br_0=1, br_n_0=0, br_tgt_0=0x100 -> q_vld_1=0, redirect_valid pulses 1 cycle, redirect_pc=0x100, br_taken_cnt=1.
REQ-034 SHALL check backpressure: out_ready=0 for 3 cycles after capture -> in_ready=0, q_* unchanged; out_ready=1 -> handshake, new bundle accepted same cycle.
REQ-035 SHALL check flush+capture same cycle: lane1 taken with flush=1 -> out_valid=0, redirect_valid=0, br_taken_cnt unchanged.
REQ-036 SHALL check counter wrap: br_taken_cnt preloaded to 0xFFFFFFFF via stimulus, one taken capture -> 0.
REQ-037 SHALL check reset mid-backpressure: rst_n=0 while out_valid=1 -> all outputs per REQ-026 next edge.
